cache_controller: RTL



---
 rtl/cache_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Control FSM for one cache instance: tag check, hit service, dirty-victim writeback,
// line fill with replay, plus the performance-counter pulses.
module cache_controller #(
    parameter bit READ_ONLY      = 1'b0,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_operation,
    output logic req_fulfilled,
    output logic hmem_req_valid,
    output logic hmem_req_operation,
    input  logic hmem_req_fulfilled,
    input  logic valid_block_match,
    input  logic valid_dirty_bit,
    input  logic counter_done,
    output logic miss_recovery_mode,
    output logic set_hmem_block_address,
    output logic use_victim_tag_for_hmem_block_address,
    output logic process_lru_counters,
    output logic clear_selected_valid_bit,
    output logic finish_new_line_install,
    output logic set_selected_dirty_bit,
    output logic clear_selected_dirty_bit,
    output logic perform_write,
    output logic reset_counter,
    output logic decrement_counter,
    output logic count_hit,
    output logic count_miss,
    output logic count_read,
    output logic count_write,
    output logic count_writeback
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITEBACK,
        S_FETCH
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_replay;
    logic   w_next_replay;
    logic   w_is_store;

    // Line length is enforced by the datapath word counter; kept for documentation only.
    logic [31:0] w_unused_words_per_line;
    assign w_unused_words_per_line = WORDS_PER_LINE;

    // A read-only cache serves every request as a LOAD.
    assign w_is_store = req_operation & ~READ_ONLY;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        w_next_state                          = r_state;
        w_next_replay                         = r_replay;
        req_fulfilled                         = 1'b0;
        hmem_req_valid                        = 1'b0;
        hmem_req_operation                    = 1'b0;
        miss_recovery_mode                    = 1'b0;
        set_hmem_block_address                = 1'b0;
        use_victim_tag_for_hmem_block_address = 1'b0;
        process_lru_counters                  = 1'b0;
        clear_selected_valid_bit              = 1'b0;
        finish_new_line_install               = 1'b0;
        set_selected_dirty_bit                = 1'b0;
        clear_selected_dirty_bit              = 1'b0;
        perform_write                         = 1'b0;
        reset_counter                         = 1'b0;
        decrement_counter                     = 1'b0;
        count_hit                             = 1'b0;
        count_miss                            = 1'b0;
        count_read                            = 1'b0;
        count_write                           = 1'b0;
        count_writeback                       = 1'b0;

        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        count_read   = ~w_is_store;
                        count_write  = w_is_store;
                        w_next_state = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (valid_block_match) begin
                        process_lru_counters   = 1'b1;
                        req_fulfilled          = 1'b1;
                        perform_write          = w_is_store;
                        set_selected_dirty_bit = w_is_store;
                        count_hit              = ~r_replay;
                        w_next_replay          = 1'b0;
                        w_next_state           = S_IDLE;
                    end else begin
                        count_miss             = 1'b1;
                        set_hmem_block_address = 1'b1;
                        reset_counter          = 1'b1;
                        if (valid_dirty_bit && !READ_ONLY) begin
                            use_victim_tag_for_hmem_block_address = 1'b1;
                            count_writeback                       = 1'b1;
                            w_next_state                          = S_WRITEBACK;
                        end else begin
                            clear_selected_valid_bit = 1'b1;
                            w_next_state             = S_FETCH;
                        end
                    end
                end
                S_WRITEBACK: begin
                    miss_recovery_mode = 1'b1;
                    hmem_req_valid     = 1'b1;
                    hmem_req_operation = 1'b1;
                    if (hmem_req_fulfilled) begin
                        // Last victim word: retarget the hmem address at the request tag.
                        if (counter_done) begin
                            clear_selected_dirty_bit = 1'b1;
                            clear_selected_valid_bit = 1'b1;
                            set_hmem_block_address   = 1'b1;
                            reset_counter            = 1'b1;
                            w_next_state             = S_FETCH;
                        end else begin
                            decrement_counter = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    miss_recovery_mode = 1'b1;
                    hmem_req_valid     = 1'b1;
                    if (hmem_req_fulfilled) begin
                        perform_write     = 1'b1;
                        decrement_counter = 1'b1;
                        if (counter_done) begin
                            finish_new_line_install = 1'b1;
                            w_next_replay           = 1'b1;
                            w_next_state            = S_CHECK;
                        end
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state  <= S_IDLE;
            r_replay <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_replay <= w_next_replay;
        end
    end

endmodule
